// File: rtl/alu_control_seq_if.sv
// Handshake bundle between the main control unit (master) and the
// registered ALU control sequencer (slave).
interface alu_control_seq_if #(
    parameter int SEL_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ALUOp;
    logic [9:0]       func_field;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] ALU_SEL;
    logic             illegal;
    logic             mc_start;
    logic             busy;

    modport master (
        output in_valid, ALUOp, func_field, out_ready,
        input  in_ready, out_valid, ALU_SEL, illegal, mc_start, busy
    );

    modport slave (
        input  in_valid, ALUOp, func_field, out_ready,
        output in_ready, out_valid, ALU_SEL, illegal, mc_start, busy
    );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with handshake and multi-cycle M-ext sequencing.
// Define RV32M_EN to enable MUL/DIV decode and the BUSY/latency-counter path.
module alu_control_seq #(
    parameter int SEL_W   = 5,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 34,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_control_seq_if.slave   bus
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;

    if (SEL_W < 5) begin : gSelWidthCheck
        $error("alu_control_seq: SEL_W must be at least 5");
    end
    if ((2 ** CNT_W) <= MAX_LAT) begin : gCntWidthCheck
        $error("alu_control_seq: CNT_W too narrow for the configured latencies");
    end
    if (MUL_LAT < 1 || DIV_LAT < 1) begin : gLatCheck
        $error("alu_control_seq: latencies must be at least 1");
    end

    localparam logic [4:0] SEL_AND    = 5'd0;
    localparam logic [4:0] SEL_OR     = 5'd1;
    localparam logic [4:0] SEL_ADD    = 5'd2;
    localparam logic [4:0] SEL_SLL    = 5'd4;
    localparam logic [4:0] SEL_SRL    = 5'd5;
    localparam logic [4:0] SEL_SUB    = 5'd6;
    localparam logic [4:0] SEL_SLTU   = 5'd7;
    localparam logic [4:0] SEL_SLT    = 5'd8;
    localparam logic [4:0] SEL_XOR    = 5'd9;
    localparam logic [4:0] SEL_SRA    = 5'd10;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

`ifdef RV32M_EN
    localparam logic [4:0] SEL_MUL    = 5'd16;
    localparam logic [6:0] F7_MEXT    = 7'b0000001;

    typedef enum logic [1:0] {
        CLS_SINGLE = 2'd0,
        CLS_MUL    = 2'd1,
        CLS_DIV    = 2'd2
    } op_class_t;

    op_class_t        decCls;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mcStart_q, mcStart_d;
`endif

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             ill_q, ill_d;

    logic [6:0]       func7;
    logic [2:0]       func3;
    logic [4:0]       decSel5;
    logic             decIll;
    logic [SEL_W-1:0] decSel;
    logic             inReady;
    logic             accept;

    assign func7 = bus.func_field[9:3];
    assign func3 = bus.func_field[2:0];

    always_comb begin
        decSel5 = SEL_ADD;
        decIll  = 1'b0;
`ifdef RV32M_EN
        decCls  = CLS_SINGLE;
`endif
        case (bus.ALUOp)
            2'b00: decSel5 = SEL_ADD;
            2'b01: begin
                case (func3)
                    3'b000, 3'b001: decSel5 = SEL_SUB;
                    3'b100, 3'b101: decSel5 = SEL_SLT;
                    3'b110, 3'b111: decSel5 = SEL_SLTU;
                    default:        decIll  = 1'b1;
                endcase
            end
            2'b10: begin
                if (func7 == F7_BASE) begin
                    case (func3)
                        3'b000:  decSel5 = SEL_ADD;
                        3'b001:  decSel5 = SEL_SLL;
                        3'b010:  decSel5 = SEL_SLT;
                        3'b011:  decSel5 = SEL_SLTU;
                        3'b100:  decSel5 = SEL_XOR;
                        3'b101:  decSel5 = SEL_SRL;
                        3'b110:  decSel5 = SEL_OR;
                        default: decSel5 = SEL_AND;
                    endcase
                end else if (func7 == F7_ALT) begin
                    case (func3)
                        3'b000:  decSel5 = SEL_SUB;
                        3'b101:  decSel5 = SEL_SRA;
                        default: decIll  = 1'b1;
                    endcase
`ifdef RV32M_EN
                end else if (func7 == F7_MEXT) begin
                    // M-ext codes are contiguous: MUL-class 16..19, DIV-class 20..23.
                    decSel5 = SEL_MUL | {2'b00, func3};
                    decCls  = func3[2] ? CLS_DIV : CLS_MUL;
`endif
                end else begin
                    decIll = 1'b1;
                end
            end
            default: begin
                case (func3)
                    3'b000:  decSel5 = SEL_ADD;
                    3'b010:  decSel5 = SEL_SLT;
                    3'b011:  decSel5 = SEL_SLTU;
                    3'b100:  decSel5 = SEL_XOR;
                    3'b110:  decSel5 = SEL_OR;
                    3'b111:  decSel5 = SEL_AND;
                    3'b001: begin
                        if (func7 == F7_BASE) decSel5 = SEL_SLL;
                        else                  decIll  = 1'b1;
                    end
                    default: begin
                        if (func7 == F7_BASE)     decSel5 = SEL_SRL;
                        else if (func7 == F7_ALT) decSel5 = SEL_SRA;
                        else                      decIll  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign decSel  = decIll ? '0 : SEL_W'(decSel5);
    assign inReady = (state_q == EMPTY) || ((state_q == FULL) && bus.out_ready);
    assign accept  = bus.in_valid && inReady;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ill_d     = ill_q;
`ifdef RV32M_EN
        cnt_d     = cnt_q;
        mcStart_d = 1'b0;
`endif
        if (accept) begin
            sel_d   = decSel;
            ill_d   = decIll;
            state_d = FULL;
`ifdef RV32M_EN
            // Counter holds remaining BUSY cycles; a latency of 1 goes straight to FULL.
            if (decCls == CLS_MUL) begin
                mcStart_d = 1'b1;
                if (MUL_LAT > 1) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                end
            end else if (decCls == CLS_DIV) begin
                mcStart_d = 1'b1;
                if (DIV_LAT > 1) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(DIV_LAT - 1);
                end
            end
`endif
        end else begin
            case (state_q)
                FULL: begin
                    if (bus.out_ready) state_d = EMPTY;
                end
`ifdef RV32M_EN
                BUSY: begin
                    if (cnt_q == '0) state_d = FULL;
                    else             cnt_d   = cnt_q - 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            sel_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ill_q   <= ill_d;
        end
    end

`ifdef RV32M_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mcStart_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mcStart_q <= mcStart_d;
        end
    end

    assign bus.busy     = (state_q == BUSY);
    assign bus.mc_start = mcStart_q;
`else
    assign bus.busy     = 1'b0;
    assign bus.mc_start = 1'b0;
`endif

    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state_q == FULL);
    assign bus.ALU_SEL   = sel_q;
    assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq; honours RV32M_EN when the DUT is built with it.
module tb_alu_control_seq;

    localparam int SEL_W   = 5;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 34;
    localparam int CNT_W   = 6;

    typedef struct packed {
        logic [4:0] sel;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic [1:0] op;
        logic [9:0] ff;
        logic [4:0] sel;
        logic       ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_control_seq_if #(.SEL_W(SEL_W)) bus ();

    alu_control_seq #(
        .SEL_W  (SEL_W),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   busySeen    = 0;
    int   mcSeen      = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Drives one request and pushes its expected result at the moment it is accepted.
    task automatic applyStimulus(input logic [1:0] op, input logic [9:0] ff,
                                 input logic [4:0] sel, input logic ill, output int waited);
        waited         = 0;
        bus.in_valid   = 1'b1;
        bus.ALUOp      = op;
        bus.func_field = ff;
        #1;
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL accept timeout: in_ready 0, required 1");
        end else begin
            expQ.push_back({sel, ill});
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (bus.busy)     busySeen++;
                if (bus.mc_start) mcSeen++;
                if (bus.out_valid && bus.out_ready) begin
                    if (expQ.size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL unexpected result: ALU_SEL %0d with empty scoreboard", bus.ALU_SEL);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("ALU_SEL", 32'(bus.ALU_SEL), 32'(e.sel));
                        checkOutput("illegal", 32'(bus.illegal), 32'(e.ill));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        vec_t vecs [16];
        int   w;
`ifdef RV32M_EN
        int   busyCnt, mcCnt, readyCnt, n;
        localparam logic [4:0] MUL_EXP = 5'd16;
        localparam logic       MUL_ILL = 1'b0;
`else
        localparam logic [4:0] MUL_EXP = 5'd0;
        localparam logic       MUL_ILL = 1'b1;
`endif

        vecs = '{
            '{2'b10, {7'b0000000, 3'b001}, 5'd4,  1'b0},
            '{2'b10, {7'b0000000, 3'b101}, 5'd5,  1'b0},
            '{2'b10, {7'b0000000, 3'b111}, 5'd0,  1'b0},
            '{2'b10, {7'b0000000, 3'b110}, 5'd1,  1'b0},
            '{2'b10, {7'b0000000, 3'b010}, 5'd8,  1'b0},
            '{2'b10, {7'b0100000, 3'b101}, 5'd10, 1'b0},
            '{2'b10, {7'b0100000, 3'b111}, 5'd0,  1'b1},
            '{2'b01, {7'b0000000, 3'b010}, 5'd0,  1'b1},
            '{2'b11, {7'b0100000, 3'b001}, 5'd0,  1'b1},
            '{2'b11, {7'b0100000, 3'b101}, 5'd10, 1'b0},
            '{2'b11, {7'b1111111, 3'b000}, 5'd2,  1'b0},
            '{2'b11, {7'b0000000, 3'b001}, 5'd4,  1'b0},
            '{2'b10, {7'b1000000, 3'b000}, 5'd0,  1'b1},
            '{2'b01, {7'b0000000, 3'b001}, 5'd6,  1'b0},
            '{2'b01, {7'b1010101, 3'b101}, 5'd8,  1'b0},
            '{2'b11, {7'b0000000, 3'b011}, 5'd7,  1'b0}
        };

        bus.in_valid   = 1'b0;
        bus.ALUOp      = 2'b00;
        bus.func_field = 10'd0;
        bus.out_ready  = 1'b1;
        rst_n          = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("reset ALU_SEL",   32'(bus.ALU_SEL),   32'd0);
        checkOutput("reset illegal",   32'(bus.illegal),   32'd0);
        checkOutput("reset busy",      32'(bus.busy),      32'd0);
        checkOutput("reset mc_start",  32'(bus.mc_start),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] SUB after reset");
        applyStimulus(2'b10, {7'b0100000, 3'b000}, 5'd6, 1'b0, w);
        #1;
        checkOutput("single-cycle out_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);

        $display("[TB] streaming XOR, SLTU, ADD");
        applyStimulus(2'b11, {7'b0000000, 3'b100}, 5'd9, 1'b0, w);
        applyStimulus(2'b01, {7'b0000000, 3'b110}, 5'd7, 1'b0, w);
        checkOutput("stream bubble 2", 32'(w), 32'd0);
        applyStimulus(2'b00, {7'b1011011, 3'b011}, 5'd2, 1'b0, w);
        checkOutput("stream bubble 3", 32'(w), 32'd0);

        $display("[TB] decode table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].ff, vecs[i].sel, vecs[i].ill, w);
        end
        repeat (2) @(negedge clk);

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(2'b11, {7'b0000000, 3'b100}, 5'd9, 1'b0, w);
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("hold out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold in_ready",  32'(bus.in_ready),  32'd0);
            checkOutput("hold ALU_SEL",   32'(bus.ALU_SEL),   32'd9);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        applyStimulus(2'b01, {7'b0000000, 3'b000}, 5'd6, 1'b0, w);
        checkOutput("drain+accept same cycle", 32'(w), 32'd0);
        repeat (2) @(negedge clk);

`ifdef RV32M_EN
        $display("[TB] DIV latency");
        applyStimulus(2'b10, {7'b0000001, 3'b100}, 5'd20, 1'b0, w);
        #1;
        busyCnt = 0; mcCnt = 0; readyCnt = 0; n = 0;
        while (!bus.out_valid && n < 100) begin
            if (bus.busy)     busyCnt++;
            if (bus.mc_start) mcCnt++;
            if (bus.in_ready) readyCnt++;
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("div busy cycles", 32'(busyCnt), 32'(DIV_LAT));
        checkOutput("div mc_start pulses", 32'(mcCnt), 32'd1);
        checkOutput("div in_ready while busy", 32'(readyCnt), 32'd0);
        checkOutput("div out_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);

        $display("[TB] MUL latency");
        applyStimulus(2'b10, {7'b0000001, 3'b000}, MUL_EXP, MUL_ILL, w);
        #1;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("mul latency", 32'(n), 32'(MUL_LAT));
        @(negedge clk);

        $display("[TB] reset mid-MUL");
        applyStimulus(2'b10, {7'b0000001, 3'b001}, 5'd17, 1'b0, w);
        #1;
        checkOutput("mul busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst busy",      32'(bus.busy),      32'd0);
        checkOutput("rst out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst ALU_SEL",   32'(bus.ALU_SEL),   32'd0);
        checkOutput("rst mc_start",  32'(bus.mc_start),  32'd0);
        checkOutput("rst in_ready",  32'(bus.in_ready),  32'd1);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`else
        $display("[TB] M-ext encodings without RV32M_EN");
        applyStimulus(2'b10, {7'b0000001, 3'b000}, MUL_EXP, MUL_ILL, w);
        #1;
        checkOutput("mul single-cycle", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        applyStimulus(2'b10, {7'b0000001, 3'b100}, 5'd0, 1'b1, w);
        @(negedge clk);

        $display("[TB] reset while FULL");
        bus.out_ready = 1'b0;
        applyStimulus(2'b10, {7'b0100000, 3'b101}, 5'd10, 1'b0, w);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkOutput("rst out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst ALU_SEL",   32'(bus.ALU_SEL),   32'd0);
        checkOutput("rst in_ready",  32'(bus.in_ready),  32'd1);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
`endif

        $display("[TB] ADD after reset release");
        applyStimulus(2'b00, {7'b0000000, 3'b000}, 5'd2, 1'b0, w);
        #1;
        checkOutput("post-reset out_valid", 32'(bus.out_valid), 32'd1);
        repeat (4) @(negedge clk);
        #2;
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
`ifndef RV32M_EN
        checkOutput("busy never asserted",     32'(busySeen), 32'd0);
        checkOutput("mc_start never asserted", 32'(mcSeen),   32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
